// File: rtl/cnn_pkg.sv
// Shared conv-datapath types: activation input is 2*WIDTH signed, output is WIDTH signed.
package cnn_pkg;
  localparam int WIDTH = 9;
  typedef logic signed [2*WIDTH-1:0] act_in_t;
  typedef logic signed [WIDTH-1:0]   act_out_t;
endpackage

// File: rtl/act_rr_sched_if.sv
// Request/result bus between conv lanes, the activation scheduler and the pooling stage.
interface act_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
);
  import cnn_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
  // a producer holds valid and its data until that edge, ready may depend on valid.
  logic                      en;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*2*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      out_valid;
  logic                      out_ready;
  act_out_t                  out_data;
  logic [IDW-1:0]            out_id;
  logic                      idle;
  logic [CNTW-1:0]           done_cnt;
  logic [IDW-1:0]            dbg_rr_ptr;

  modport master (
    output en, req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, idle, done_cnt, dbg_rr_ptr
  );

  modport slave (
    input  en, req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, idle, done_cnt, dbg_rr_ptr
  );
endinterface

// File: rtl/act_rr_sched_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, else lowest set request.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);
  logic [NREQ-1:0] lo_mask;
  logic [NREQ-1:0] upper;

  assign lo_mask = (NREQ'(1) << ptr) - NREQ'(1);
  assign upper   = req & ~lo_mask;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    gnt_idx = '0;
    if (|upper) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (upper[i]) gnt_idx = IDW'(i);
      end
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[i]) gnt_idx = IDW'(i);
      end
    end
  end

  assign gnt_any = |req;
  assign gnt     = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
endmodule

// File: rtl/eq2.sv
// eq2 activation: (|X+1| + |X-1|) >>> 1 in 2*WIDTH wrapping arithmetic, packed to WIDTH bits.
module eq2
  import cnn_pkg::*;
(
  input  act_in_t  x,
  output act_out_t y
);
  localparam act_in_t ONE = act_in_t'(1);

  act_in_t xp, xm, ap, am, sum, half;

  assign xp   = x + ONE;
  assign xm   = x - ONE;
  // Negating the most negative value wraps back to itself; that is intended.
  assign ap   = xp[2*WIDTH-1] ? -xp : xp;
  assign am   = xm[2*WIDTH-1] ? -xm : xm;
  assign sum  = ap + am;
  assign half = sum >>> 1;
  assign y    = {half[2*WIDTH-1], half[WIDTH-2:0]};
endmodule

// File: rtl/act_rr_sched.sv
// Round-robin scheduler sharing one eq2 unit among NREQ conv lanes through a two-stage pipe.
module act_rr_sched
  import cnn_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input logic             clk,
  input logic             rst_n,
  act_rr_sched_if.slave   bus
);
  logic            s1_valid, s2_valid;
  act_in_t         s1_x, sel_x;
  logic [IDW-1:0]  s1_id, s2_id, rr_ptr, gnt_idx;
  act_out_t        s2_data, eq2_y;
  logic [CNTW-1:0] done_cnt;
  logic [NREQ-1:0] gnt;
  logic            adv1, adv2, grant_en, gnt_any, hs;

  assign adv2 = !s2_valid || bus.out_ready;
  assign adv1 = !s1_valid || adv2;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // rst_n gates the grant so req_ready drops the instant reset asserts.
  assign grant_en      = rst_n && bus.en && adv1;
  assign bus.req_ready = grant_en ? gnt : '0;
  assign hs            = grant_en && gnt_any;

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_x = bus.req_data[i*2*WIDTH +: 2*WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (hs) begin
      s1_valid <= 1'b1;
      s1_x     <= sel_x;
      s1_id    <= gnt_idx;
      rr_ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (adv1) begin
      s1_valid <= 1'b0;
    end
  end

  eq2 u_eq2 (
    .x (s1_x),
    .y (eq2_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= eq2_y;
        s2_id   <= s1_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (s2_valid && bus.out_ready) begin
      done_cnt <= done_cnt + CNTW'(1);
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_data   = s2_data;
  assign bus.out_id     = s2_id;
  assign bus.done_cnt   = done_cnt;
  assign bus.idle       = !bus.en && !s1_valid && !s2_valid;
  assign bus.dbg_rr_ptr = rr_ptr;
endmodule

// File: tb/tb_act_rr_sched.sv
// Bench for act_rr_sched: reference grant/pipe model feeds an expected-result queue.
module tb_act_rr_sched;
  import cnn_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;
  localparam int XW   = 2 * WIDTH;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [IDW+WIDTH-1:0] exp_q[$];

  act_rr_sched_if #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus ();

  act_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected bench to finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic longint wrap_x(input longint v);
    longint m;
    longint r;
    m = longint'(1) << XW;
    r = ((v % m) + m) % m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] model_eq2(input logic [XW-1:0] xr);
    longint xv, a, b, s, r;
    xv = longint'(xr);
    if (xr[XW-1]) xv = xv - (longint'(1) << XW);
    a = wrap_x(xv + 1);
    b = wrap_x(xv - 1);
    a = wrap_x(a < 0 ? -a : a);
    b = wrap_x(b < 0 ? -b : b);
    s = wrap_x(a + b);
    r = s >>> 1;
    return {r[XW-1], r[WIDTH-2:0]};
  endfunction

  int                       m_ptr;
  bit                       m_s1, m_s2;
  bit                       mon_a1, mon_a2;
  int                       mon_g;
  logic [NREQ-1:0]          mon_rdy;
  logic [NREQ*XW-1:0]       mon_tmp;
  logic [IDW+WIDTH-1:0]     mon_exp;

  // Scoreboard: predict grants and outputs at negedge, ahead of the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = 0;
      m_s1  = 1'b0;
      m_s2  = 1'b0;
      exp_q.delete();
    end else begin
      mon_a2 = !m_s2 || bus.out_ready;
      mon_a1 = !m_s1 || mon_a2;
      mon_g  = -1;
      if (bus.en && mon_a1) begin
        for (int i = 0; i < NREQ; i++) begin
          if (mon_g < 0 && bus.req_valid[(m_ptr + i) % NREQ]) mon_g = (m_ptr + i) % NREQ;
        end
      end
      mon_rdy = '0;
      if (mon_g >= 0) mon_rdy[mon_g] = 1'b1;
      n_checks++;
      if (bus.req_ready !== mon_rdy) begin
        n_fail++;
        $display("FAIL grant @%0t: req_ready=%b expected %b", $time, bus.req_ready, mon_rdy);
      end
      n_checks++;
      if (bus.out_valid !== m_s2) begin
        n_fail++;
        $display("FAIL out_valid @%0t: got %b expected %b", $time, bus.out_valid, m_s2);
      end
      if (m_s2 && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty @%0t: got result id=%0d data=%0h expected none", $time, bus.out_id, bus.out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({bus.out_id, bus.out_data} !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_result @%0t: got id=%0d data=%0h expected id=%0d data=%0h",
                     $time, bus.out_id, bus.out_data, mon_exp[IDW+WIDTH-1:WIDTH], mon_exp[WIDTH-1:0]);
          end
        end
      end
      if (mon_g >= 0) begin
        mon_tmp = bus.req_data >> (mon_g * XW);
        exp_q.push_back({IDW'(mon_g), model_eq2(mon_tmp[XW-1:0])});
      end
      if (mon_a2) m_s2 = m_s1;
      if (mon_a1) m_s1 = (mon_g >= 0);
      if (mon_g >= 0) m_ptr = (mon_g + 1) % NREQ;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [XW-1:0] x);
    bus.req_data[lane*XW +: XW] = x;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    bus.req_valid = '0;
    repeat (n) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %0h expected 0", bus.out_data); end
    n_checks++; if (bus.out_id !== '0) begin n_fail++; $display("FAIL rst_out_id: got %0d expected 0", bus.out_id); end
    n_checks++; if (bus.done_cnt !== '0) begin n_fail++; $display("FAIL rst_done_cnt: got %0d expected 0", bus.done_cnt); end
    n_checks++; if (bus.idle !== 1'b0) begin n_fail++; $display("FAIL rst_idle_en1: got %b expected 0", bus.idle); end
    bus.en = 1'b0;
    #1;
    n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle_en0: got %b expected 1", bus.idle); end
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    set_lane(0, '0);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1: out_valid=%b expected 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_lat2: out_valid=%b expected 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 9'd1) begin n_fail++; $display("FAIL single_data: got %0d expected 1", bus.out_data); end
    n_checks++; if (bus.out_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", bus.out_id); end
    tick();
    n_checks++; if (bus.done_cnt !== 16'd1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", bus.done_cnt); end
  endtask

  task automatic test_round_robin();
    logic [IDW-1:0]   exp_id [4];
    logic [WIDTH-1:0] exp_d  [4];
    int k;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_d  = '{9'd5, 9'd3, 9'd44, 9'd1};
    apply_reset();
    bus.en = 1'b1;
    set_lane(0, 18'sd5);
    set_lane(1, -18'sd3);
    set_lane(2, 18'sd300);
    set_lane(3, -18'sd1);
    bus.req_valid = '1;
    k = 0;
    repeat (12) begin
      tick();
      if (bus.out_valid) begin
        n_checks++;
        if (bus.out_id !== exp_id[k % 4] || bus.out_data !== exp_d[k % 4]) begin
          n_fail++;
          $display("FAIL rr_seq[%0d]: got id=%0d data=%0d expected id=%0d data=%0d",
                   k, bus.out_id, bus.out_data, exp_id[k % 4], exp_d[k % 4]);
        end
        k++;
      end
    end
    drain(3);
    n_checks++; if (k != 11) begin n_fail++; $display("FAIL rr_count: got %0d expected 11", k); end
    n_checks++; if (bus.done_cnt !== 16'd12) begin n_fail++; $display("FAIL rr_done: got %0d expected 12", bus.done_cnt); end
  endtask

  task automatic test_stall();
    int hs;
    logic [WIDTH-1:0] held_d;
    logic [IDW-1:0]   held_id;
    hs = 0;
    held_d  = '0;
    held_id = '0;
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (|bus.req_ready) hs++;
      if (c == 2) begin
        held_d  = bus.out_data;
        held_id = bus.out_id;
      end
      if (c > 2) begin
        n_checks++;
        if (bus.out_data !== held_d || bus.out_id !== held_id) begin
          n_fail++;
          $display("FAIL stall_stable: got id=%0d data=%0h expected id=%0d data=%0h",
                   bus.out_id, bus.out_data, held_id, held_d);
        end
      end
      tick();
    end
    n_checks++; if (hs != 2) begin n_fail++; $display("FAIL stall_hs: got %0d expected 2", hs); end
    n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL stall_ready: got %b expected 0", bus.req_ready); end
    bus.out_ready = 1'b1;
    repeat (3) tick();
    drain(4);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_loss: %0d results outstanding, expected 0", exp_q.size()); end
  endtask

  task automatic test_ptr_wrap();
    apply_reset();
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_g1: got %b expected 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL wrap_ptr1: got %0d expected 3", bus.dbg_rr_ptr); end
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_g2: got %b expected 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL wrap_ptr2: got %0d expected 3", bus.dbg_rr_ptr); end
    bus.req_valid = 4'b0101;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_g3: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.dbg_rr_ptr !== 2'd1) begin n_fail++; $display("FAIL wrap_ptr3: got %0d expected 1", bus.dbg_rr_ptr); end
    drain(3);
  endtask

  task automatic test_drain();
    int dlv;
    dlv = 0;
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = '1;
    tick();
    tick();
    bus.en = 1'b0;
    #1;
    n_checks++; if (bus.idle !== 1'b0) begin n_fail++; $display("FAIL drain_busy: idle=%b expected 0", bus.idle); end
    for (int c = 0; c < 6 && dlv < 2; c++) begin
      @(negedge clk);
      n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL drain_nogrant: got %b expected 0", bus.req_ready); end
      if (bus.out_valid && bus.out_ready) dlv++;
      tick();
    end
    n_checks++; if (dlv != 2) begin n_fail++; $display("FAIL drain_count: got %0d expected 2", dlv); end
    n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle: got %b expected 1", bus.idle); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_overflow();
    int n;
    n = 0;
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    set_lane(1, 18'h1FFFF);
    set_lane(3, 18'h20000);
    bus.req_valid = 4'b1010;
    tick();
    tick();
    bus.req_valid = '0;
    repeat (4) begin
      if (bus.out_valid) begin
        n++;
        n_checks++;
        if (bus.out_data !== 9'h1FF) begin n_fail++; $display("FAIL ovf_data: got %0h expected 1ff", bus.out_data); end
      end
      tick();
    end
    n_checks++; if (n != 2) begin n_fail++; $display("FAIL ovf_count: got %0d expected 2", n); end
  endtask

  task automatic test_async_reset();
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = '1;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.done_cnt !== '0) begin n_fail++; $display("FAIL arst_done: got %0d expected 0", bus.done_cnt); end
    n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL arst_ready: got %b expected 0", bus.req_ready); end
    n_checks++; if (bus.out_data !== '0 || bus.out_id !== '0) begin
      n_fail++; $display("FAIL arst_out: got id=%0d data=%0h expected 0/0", bus.out_id, bus.out_data);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL arst_first: got %b expected 0001", bus.req_ready); end
    tick();
    drain(4);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_ptr_wrap();
    test_drain();
    test_overflow();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue: %0d outstanding, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
